hc595_ctrl: RTL

//  Serial driver for two cascaded 74HC595 registers feeding the 8-digit common-anode display.

---
 rtl/hc595_ctrl_pkg.sv | 28 ++
 rtl/hc595_phase_cnt.sv | 52 +++++
 rtl/hc595_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/hc595_ctrl_pkg.sv
// ============================================================================
//  Module      : hc595_ctrl_pkg
//  Description : Shared constants, state encoding and parameter legality check
//                for the dual 74HC595 serial display driver.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package hc595_ctrl_pkg;

    // Two cascaded 595s: 8 segment bits followed by 8 digit-select bits.
    localparam int FRAME_BITS = 16;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2
    } state_t;

    // SHCP needs a clean half-period split, so the divider must be even and >= 2.
    function automatic bit div_cnt_legal(input int div_cnt);
        return (div_cnt >= 2) && ((div_cnt % 2) == 0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/hc595_phase_cnt.sv
// ============================================================================
//  Module      : hc595_phase_cnt
//  Description : Phase counter 0..DIV_CNT-1 with wrap flag. Also provides the
//                half-period and last-phase compares for the *next* phase so
//                the parent can register shcp/stcp/frame_done glitch-free.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module hc595_phase_cnt #(
    parameter int DIV_CNT = 4
) (
    input  logic clk,
    input  logic rst,          // asynchronous, active low
    input  logic i_clear,      // force the next phase to 0
    output logic o_wrap,       // current phase is DIV_CNT-1
    output logic o_half_nxt,   // next phase is in the upper half period
    output logic o_last_nxt    // next phase is DIV_CNT-1
);

    localparam int               c_PW   = $clog2(DIV_CNT);
    localparam logic [c_PW-1:0]  c_LAST = c_PW'(DIV_CNT - 1);
    localparam logic [c_PW-1:0]  c_HALF = c_PW'(DIV_CNT / 2);

    logic [c_PW-1:0] r_phase;
    logic [c_PW-1:0] w_phase_nxt;

    // Next phase: wrap at the end of a period, or restart on request.
    always_comb begin
        w_phase_nxt = r_phase + c_PW'(1);
        if (i_clear || (r_phase == c_LAST)) begin
            w_phase_nxt = '0;
        end
    end

    // Phase register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_phase <= '0;
        end else begin
            r_phase <= w_phase_nxt;
        end
    end

    assign o_wrap     = (r_phase == c_LAST);
    assign o_half_nxt = (w_phase_nxt >= c_HALF);
    assign o_last_nxt = (w_phase_nxt == c_LAST);

endmodule

`default_nettype wire

// File: rtl/hc595_ctrl.sv
// ============================================================================
//  Module      : hc595_ctrl
//  Description : Continuous serial refresh of two cascaded 74HC595s. Each
//                frame snapshots {seg, sel}, shifts 16 bits MSB first on
//                DS/SHCP, then pulses STCP. All pins are registered.
//                Optional feature macro: HC595_BLANK_EN adds a per-frame
//                `blank` input that forces oe_n high for that frame.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module hc595_ctrl
    import hc595_ctrl_pkg::*;
#(
    parameter int DIV_CNT = 4
) (
    input  logic       clk,
    input  logic       rst,         // asynchronous, active low
    input  logic [7:0] sel,
    input  logic [7:0] seg,
`ifdef HC595_BLANK_EN
    input  logic       blank,
`endif
    output logic       ds,
    output logic       shcp,
    output logic       stcp,
    output logic       oe_n,
    output logic       frame_done
);

    if (!div_cnt_legal(DIV_CNT)) begin : g_div_cnt_illegal
        $error("hc595_ctrl: DIV_CNT must be even and >= 2");
    end

    state_t                  r_state, w_state_nxt;
    logic [FRAME_BITS-1:0]   r_word, w_word_nxt;
    logic [3:0]              r_bit_idx, w_bit_idx_nxt;
    logic                    w_new_bit;

    logic w_wrap, w_half_nxt, w_last_nxt;

    logic r_ds, r_shcp, r_stcp, r_oe_n, r_done, r_armed;
    logic w_ds_nxt, w_shcp_nxt, w_stcp_nxt, w_oe_n_nxt, w_done_nxt, w_armed_nxt;

    hc595_phase_cnt #(
        .DIV_CNT    (DIV_CNT)
    ) u_phase_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (r_state == ST_LOAD),
        .o_wrap     (w_wrap),
        .o_half_nxt (w_half_nxt),
        .o_last_nxt (w_last_nxt)
    );

    // Frame sequencing: snapshot in LOAD, walk bit_idx down in SHIFT, then LATCH.
    always_comb begin
        w_state_nxt   = r_state;
        w_word_nxt    = r_word;
        w_bit_idx_nxt = r_bit_idx;
        w_new_bit     = 1'b0;
        case (r_state)
            ST_LOAD: begin
                w_state_nxt   = ST_SHIFT;
                w_word_nxt    = {seg, sel};
                w_bit_idx_nxt = 4'(FRAME_BITS - 1);
                w_new_bit     = 1'b1;
            end
            ST_SHIFT: begin
                if (w_wrap) begin
                    if (r_bit_idx == 4'd0) begin
                        w_state_nxt = ST_LATCH;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx - 4'd1;
                        w_new_bit     = 1'b1;
                    end
                end
            end
            ST_LATCH: begin
                if (w_wrap) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            default: begin
                w_state_nxt = ST_LOAD;
            end
        endcase
    end

`ifdef HC595_BLANK_EN
    logic r_blank, w_blank_nxt;

    // Blank request is only taken at LOAD so it covers exactly one frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_blank <= 1'b0;
        end else begin
            r_blank <= w_blank_nxt;
        end
    end
`endif

    // Pin values for the upcoming cycle, derived from next state and next phase
    // so that the registered pins line up with the state they describe.
    always_comb begin
        w_ds_nxt    = w_new_bit ? w_word_nxt[w_bit_idx_nxt] : r_ds;
        w_shcp_nxt  = (w_state_nxt == ST_SHIFT) && w_half_nxt;
        w_stcp_nxt  = (w_state_nxt == ST_LATCH) && w_half_nxt;
        w_done_nxt  = (w_state_nxt == ST_LATCH) && w_last_nxt;
        // Outputs stay blanked until the first complete latch has finished.
        w_armed_nxt = r_armed | (r_stcp & ~w_stcp_nxt);
`ifdef HC595_BLANK_EN
        w_blank_nxt = (r_state == ST_LOAD) ? blank : r_blank;
        w_oe_n_nxt  = ~w_armed_nxt | w_blank_nxt;
`else
        w_oe_n_nxt  = ~w_armed_nxt;
`endif
    end

    // State, word, bit index and all pin registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_LOAD;
            r_word    <= '0;
            r_bit_idx <= '0;
            r_ds      <= 1'b0;
            r_shcp    <= 1'b0;
            r_stcp    <= 1'b0;
            r_oe_n    <= 1'b1;
            r_done    <= 1'b0;
            r_armed   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_word    <= w_word_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_ds      <= w_ds_nxt;
            r_shcp    <= w_shcp_nxt;
            r_stcp    <= w_stcp_nxt;
            r_oe_n    <= w_oe_n_nxt;
            r_done    <= w_done_nxt;
            r_armed   <= w_armed_nxt;
        end
    end

    assign ds         = r_ds;
    assign shcp       = r_shcp;
    assign stcp       = r_stcp;
    assign oe_n       = r_oe_n;
    assign frame_done = r_done;

endmodule

`default_nettype wire
